// File: rtl/cuckoo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cuckoo_pkg
// Brief    : Shared types and constants for the two-table cuckoo insert path.
// Revision : 1.0 - initial release
// ============================================================================
package cuckoo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_IDX_W  = 5;

    localparam logic TBL1 = 1'b0;
    localparam logic TBL2 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                      filled;
        logic [DEFAULT_DATA_W-1:0] key;
        logic [DEFAULT_IDX_W-1:0]  alt;
    } slot_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    function automatic logic other_tbl(input logic sel);
        return (sel == TBL1) ? TBL2 : TBL1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cuckoo_stats.sv
`default_nettype none
// ============================================================================
// Module   : cuckoo_stats
// Brief    : Occupancy and saturating failure counters fed by insert completions.
// Revision : 1.0 - initial release
// ============================================================================
module cuckoo_stats
    import cuckoo_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done_valid,
    input  logic             done_ok,
    output logic [IDX_W+1:0] occupancy,
    output logic [7:0]       fail_count
);

    localparam logic [IDX_W+1:0] OCC_ONE = {{(IDX_W+1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy  <= '0;
            fail_count <= 8'd0;
        end else if (done_valid) begin
            if (done_ok) begin
                occupancy <= occupancy + OCC_ONE;
            end else begin
                fail_count <= sat_inc8(fail_count);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cuckoo_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cuckoo_insert_ctrl
// Brief    : Place-or-evict sequencer driving the shared two-table port.
// Revision : 1.0 - initial release
// ============================================================================
module cuckoo_insert_ctrl
    import cuckoo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int IDX_W     = DEFAULT_IDX_W,
    parameter int MAX_KICKS = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_key,
    input  logic [IDX_W-1:0]  in_idx1,
    input  logic [IDX_W-1:0]  in_idx2,

    output logic              tbl_rd_en,
    output logic              tbl_wr_en,
    output logic              tbl_sel,
    output logic [IDX_W-1:0]  tbl_addr,
    output logic [DATA_W-1:0] tbl_wr_key,
    output logic [IDX_W-1:0]  tbl_wr_alt,
    input  logic              tbl_rd_filled,
    input  logic [DATA_W-1:0] tbl_rd_key,
    input  logic [IDX_W-1:0]  tbl_rd_alt,

    output logic              done_valid,
    output logic              done_ok,
    output logic [IDX_W:0]    done_kicks,
    output logic [DATA_W-1:0] fail_key,
    output logic [IDX_W+1:0]  occupancy,
    output logic [7:0]        fail_count
);

    localparam logic [IDX_W:0] KICK_LIMIT = MAX_KICKS[IDX_W:0];
    localparam logic [IDX_W:0] KICK_ONE   = {{IDX_W{1'b0}}, 1'b1};

    state_t              state;
    logic [DATA_W-1:0]   cur_key;
    logic                cur_sel;
    logic [IDX_W-1:0]    cur_addr;
    logic [IDX_W-1:0]    cur_alt;
    logic [IDX_W:0]      kicks;

    logic [IDX_W:0]      kicks_inc;
    logic                limit_hit;
    logic                next_sel;

    assign kicks_inc = kicks + KICK_ONE;
    assign limit_hit = (kicks_inc == KICK_LIMIT);
    assign next_sel  = other_tbl(cur_sel);

    // Strobes and port fields are registered one state ahead, so they are
    // valid for exactly the cycle the FSM sits in READ or CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_key    <= '0;
            cur_sel    <= TBL1;
            cur_addr   <= '0;
            cur_alt    <= '0;
            kicks      <= '0;
            in_ready   <= 1'b1;
            tbl_rd_en  <= 1'b0;
            tbl_wr_en  <= 1'b0;
            tbl_sel    <= TBL1;
            tbl_addr   <= '0;
            tbl_wr_key <= '0;
            tbl_wr_alt <= '0;
            done_valid <= 1'b0;
            done_ok    <= 1'b0;
            done_kicks <= '0;
            fail_key   <= '0;
        end else begin
            tbl_rd_en  <= 1'b0;
            tbl_wr_en  <= 1'b0;
            tbl_sel    <= TBL1;
            tbl_addr   <= '0;
            tbl_wr_key <= '0;
            tbl_wr_alt <= '0;
            done_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        cur_key   <= in_key;
                        cur_sel   <= TBL1;
                        cur_addr  <= in_idx1;
                        cur_alt   <= in_idx2;
                        kicks     <= '0;
                        in_ready  <= 1'b0;
                        tbl_rd_en <= 1'b1;
                        tbl_sel   <= TBL1;
                        tbl_addr  <= in_idx1;
                        state     <= ST_READ;
                    end
                end

                ST_READ: begin
                    tbl_wr_en  <= 1'b1;
                    tbl_sel    <= cur_sel;
                    tbl_addr   <= cur_addr;
                    tbl_wr_key <= cur_key;
                    tbl_wr_alt <= cur_alt;
                    state      <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (!tbl_rd_filled) begin
                        done_ok    <= 1'b1;
                        done_kicks <= kicks;
                        done_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        // The old occupant now carries the slot it was evicted from
                        // as its alternate and heads for its stored alternate slot.
                        cur_key  <= tbl_rd_key;
                        cur_alt  <= cur_addr;
                        cur_addr <= tbl_rd_alt;
                        cur_sel  <= next_sel;
                        kicks    <= kicks_inc;
                        if (limit_hit) begin
                            done_ok    <= 1'b0;
                            done_kicks <= kicks_inc;
                            fail_key   <= tbl_rd_key;
                            done_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            tbl_rd_en <= 1'b1;
                            tbl_sel   <= next_sel;
                            tbl_addr  <= tbl_rd_alt;
                            state     <= ST_READ;
                        end
                    end
                end

                ST_DONE: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    cuckoo_stats #(
        .IDX_W (IDX_W)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .done_valid (done_valid),
        .done_ok    (done_ok),
        .occupancy  (occupancy),
        .fail_count (fail_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cuckoo_insert_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cuckoo_insert_ctrl
// Brief    : Directed bench with an algorithmic insert model and a table memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cuckoo_insert_ctrl;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int MK = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_key;
    logic [IW-1:0] in_idx1, in_idx2;
    logic          tbl_rd_en, tbl_wr_en, tbl_sel;
    logic [IW-1:0] tbl_addr, tbl_wr_alt;
    logic [DW-1:0] tbl_wr_key;
    logic          tbl_rd_filled;
    logic [DW-1:0] tbl_rd_key;
    logic [IW-1:0] tbl_rd_alt;
    logic          done_valid, done_ok;
    logic [IW:0]   done_kicks;
    logic [DW-1:0] fail_key;
    logic [IW+1:0] occupancy;
    logic [7:0]    fail_count;

    always #5 clk = ~clk;

    cuckoo_insert_ctrl #(.DATA_W(DW), .IDX_W(IW), .MAX_KICKS(MK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_idx1(in_idx1), .in_idx2(in_idx2),
        .tbl_rd_en(tbl_rd_en), .tbl_wr_en(tbl_wr_en), .tbl_sel(tbl_sel),
        .tbl_addr(tbl_addr), .tbl_wr_key(tbl_wr_key), .tbl_wr_alt(tbl_wr_alt),
        .tbl_rd_filled(tbl_rd_filled), .tbl_rd_key(tbl_rd_key), .tbl_rd_alt(tbl_rd_alt),
        .done_valid(done_valid), .done_ok(done_ok), .done_kicks(done_kicks),
        .fail_key(fail_key), .occupancy(occupancy), .fail_count(fail_count)
    );

    // Table memory: preload/clear port for the bench, read data one cycle late.
    logic          mem_f [0:1][0:31];
    logic [DW-1:0] mem_k [0:1][0:31];
    logic [IW-1:0] mem_a [0:1][0:31];
    logic          pl_en, pl_clr, pl_sel;
    logic [IW-1:0] pl_addr, pl_alt;
    logic [DW-1:0] pl_key;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 32; j++) begin
                    mem_f[i][j] <= 1'b0;
                    mem_k[i][j] <= '0;
                    mem_a[i][j] <= '0;
                end
        end else if (pl_en) begin
            mem_f[pl_sel][pl_addr] <= 1'b1;
            mem_k[pl_sel][pl_addr] <= pl_key;
            mem_a[pl_sel][pl_addr] <= pl_alt;
        end else if (tbl_wr_en) begin
            mem_f[tbl_sel][tbl_addr] <= 1'b1;
            mem_k[tbl_sel][tbl_addr] <= tbl_wr_key;
            mem_a[tbl_sel][tbl_addr] <= tbl_wr_alt;
        end
        if (tbl_rd_en) begin
            tbl_rd_filled <= mem_f[tbl_sel][tbl_addr];
            tbl_rd_key    <= mem_k[tbl_sel][tbl_addr];
            tbl_rd_alt    <= mem_a[tbl_sel][tbl_addr];
        end else begin
            tbl_rd_filled <= 1'b0;
            tbl_rd_key    <= '0;
            tbl_rd_alt    <= '0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          rd, wr, sel;
        logic [IW-1:0] addr;
        logic [DW-1:0] wkey;
        logic [IW-1:0] walt;
        logic          dv, ok;
        logic [IW:0]   kicks;
        logic [DW-1:0] fkey;
    } ent_t;

    typedef struct {
        string       name;
        logic [63:0] got;
        logic [63:0] want;
    } lit_t;

    ent_t q[$];
    lit_t lits[$];

    // Reference tables: the model's own view of both tables.
    logic          m_f [0:1][0:31];
    logic [DW-1:0] m_k [0:1][0:31];
    logic [IW-1:0] m_a [0:1][0:31];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic lit(input string n, input logic [63:0] g, input logic [63:0] w);
        lit_t l;
        l.name = n; l.got = g; l.want = w;
        lits.push_back(l);
    endtask

    // Walks the whole eviction chain and lays out the per-cycle port trace.
    task automatic model_insert(input logic [DW-1:0] k, input logic [IW-1:0] i1,
                                input logic [IW-1:0] i2, input int base);
        ent_t e;
        logic s = 1'b0;
        logic [IW-1:0] a = i1, ca = i2, ea;
        logic [DW-1:0] ck = k, ek;
        logic was, ok = 1'b0;
        logic [DW-1:0] fk = '0;
        int n = 0;
        int c = base;
        for (int g = 0; g < 64; g++) begin
            e = '{cyc:c, rd:1'b1, wr:1'b0, sel:s, addr:a, wkey:'0, walt:'0,
                  dv:1'b0, ok:1'b0, kicks:'0, fkey:'0};
            q.push_back(e); c++;
            e = '{cyc:c, rd:1'b0, wr:1'b1, sel:s, addr:a, wkey:ck, walt:ca,
                  dv:1'b0, ok:1'b0, kicks:'0, fkey:'0};
            q.push_back(e); c++;
            was = m_f[s][a]; ek = m_k[s][a]; ea = m_a[s][a];
            m_f[s][a] = 1'b1; m_k[s][a] = ck; m_a[s][a] = ca;
            if (!was) begin ok = 1'b1; break; end
            n++;
            ck = ek; ca = a; a = ea; s = ~s;
            if (n == MK) begin ok = 1'b0; fk = ek; break; end
        end
        e = '{cyc:c, rd:1'b0, wr:1'b0, sel:1'b0, addr:'0, wkey:'0, walt:'0,
              dv:1'b1, ok:ok, kicks:(IW+1)'(n), fkey:fk};
        q.push_back(e);
    endtask

    // Compare process: model state below is written only here.
    logic          m_ok;
    logic [IW:0]   m_kicks;
    logic [DW-1:0] m_fkey;
    logic [IW+1:0] m_occ;
    logic [7:0]    m_fail;

    task automatic check(input string n, input logic [63:0] g, input logic [63:0] w);
        n_checks++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h want %h", n, cyc, g, w);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        lit_t l;
        bit busy;
        logic [46:0] eb, ab;
        busy = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_ok = 1'b0; m_kicks = '0; m_fkey = '0; m_occ = '0; m_fail = 8'd0;
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            busy = 1'b1;
        end
        if (busy) eb = {1'b0, e.rd, e.wr, e.sel, e.addr, e.wkey, e.walt, e.dv};
        else      eb = {1'b1, 46'd0};
        ab = {in_ready, tbl_rd_en, tbl_wr_en, tbl_sel, tbl_addr, tbl_wr_key, tbl_wr_alt, done_valid};
        check("port_bus", 64'(ab), 64'(eb));
        if (busy && e.dv) begin
            m_ok = e.ok; m_kicks = e.kicks;
            if (!e.ok) m_fkey = e.fkey;
        end
        check("done_regs", 64'({done_ok, done_kicks, fail_key}), 64'({m_ok, m_kicks, m_fkey}));
        check("stats", 64'({occupancy, fail_count}), 64'({m_occ, m_fail}));
        if (busy && e.dv) begin
            if (e.ok) m_occ = m_occ + 1'b1;
            else if (m_fail != 8'd255) m_fail = m_fail + 8'd1;
        end
        while (lits.size() > 0) begin
            l = lits.pop_front();
            check(l.name, l.got, l.want);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_tables();
        pl_clr = 1'b1; step(); pl_clr = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) begin
                m_f[i][j] = 1'b0; m_k[i][j] = '0; m_a[i][j] = '0;
            end
    endtask

    task automatic preload(input logic s, input logic [IW-1:0] a,
                           input logic [DW-1:0] k, input logic [IW-1:0] al);
        pl_sel = s; pl_addr = a; pl_key = k; pl_alt = al; pl_en = 1'b1;
        step(); pl_en = 1'b0;
        m_f[s][a] = 1'b1; m_k[s][a] = k; m_a[s][a] = al;
    endtask

    task automatic insert(input logic [DW-1:0] k, input logic [IW-1:0] i1,
                          input logic [IW-1:0] i2, input bit hold);
        bit acc = 1'b0;
        in_valid = 1'b1; in_key = k; in_idx1 = i1; in_idx2 = i2;
        for (int t = 0; t < 100 && !acc; t++) begin
            if (in_ready) begin
                model_insert(k, i1, i2, cyc + 1);
                acc = 1'b1;
            end
            step();
        end
        if (!hold) in_valid = 1'b0;
        if (!acc) lit("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            step();
            if (q.size() == 0) fin = 1'b1;
        end
        if (!fin) lit("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_key = '0; in_idx1 = '0; in_idx2 = '0;
        pl_en = 1'b0; pl_clr = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_key = '0; pl_alt = '0;
        repeat (3) step();
        lit("reset_outputs", 64'({in_ready, occupancy, fail_count, done_ok}), 64'({1'b1, 7'd0, 8'd0, 1'b0}));
        rst_n = 1'b1;
        clear_tables();

        // Empty slot: placed directly.
        insert(32'hA5, 5'd3, 5'd7, 1'b0);
        wait_done();
        lit("t1_slot", 64'({mem_f[0][3], mem_k[0][3], mem_a[0][3]}), 64'({1'b1, 32'hA5, 5'd7}));
        lit("t1_done", 64'({done_ok, done_kicks}), 64'({1'b1, 6'd0}));
        lit("t1_occ", 64'(occupancy), 64'd1);

        // One eviction into an empty table-2 slot.
        clear_tables();
        preload(1'b0, 5'd3, 32'h11, 5'd9);
        insert(32'h22, 5'd3, 5'd5, 1'b0);
        wait_done();
        lit("t2_t1slot", 64'({mem_f[0][3], mem_k[0][3], mem_a[0][3]}), 64'({1'b1, 32'h22, 5'd5}));
        lit("t2_t2slot", 64'({mem_f[1][9], mem_k[1][9], mem_a[1][9]}), 64'({1'b1, 32'h11, 5'd3}));
        lit("t2_done", 64'({done_ok, done_kicks}), 64'({1'b1, 6'd1}));
        lit("t2_occ", 64'(occupancy), 64'd2);

        // Kick limit: 0x11 lands in T2[9], 0x33 is left homeless.
        clear_tables();
        preload(1'b0, 5'd3, 32'h11, 5'd9);
        preload(1'b1, 5'd9, 32'h33, 5'd3);
        insert(32'h22, 5'd3, 5'd5, 1'b0);
        wait_done();
        lit("t3_done", 64'({done_ok, done_kicks, fail_key}), 64'({1'b0, 6'd2, 32'h33}));
        lit("t3_stats", 64'({occupancy, fail_count}), 64'({7'd2, 8'd1}));

        // Back-to-back requests with in_valid held high.
        clear_tables();
        insert(32'h44, 5'd1, 5'd2, 1'b1);
        insert(32'h55, 5'd1, 5'd4, 1'b0);
        wait_done();
        lit("hold_t1slot", 64'({mem_f[0][1], mem_k[0][1], mem_a[0][1]}), 64'({1'b1, 32'h55, 5'd4}));
        lit("hold_t2slot", 64'({mem_f[1][2], mem_k[1][2], mem_a[1][2]}), 64'({1'b1, 32'h44, 5'd1}));
        lit("hold_done", 64'({done_ok, done_kicks}), 64'({1'b1, 6'd1}));

        // Reset asserted in the CHECK cycle must suppress the pending write.
        clear_tables();
        insert(32'h66, 5'd6, 5'd7, 1'b0);
        step();
        rst_n = 1'b0;
        repeat (2) step();
        lit("rst_no_write", 64'(mem_f[0][6]), 64'd0);
        lit("rst_outputs", 64'({in_ready, tbl_wr_en, occupancy, fail_count}), 64'({1'b1, 1'b0, 7'd0, 8'd0}));
        rst_n = 1'b1;
        clear_tables();
        insert(32'h77, 5'd6, 5'd7, 1'b0);
        wait_done();
        lit("post_rst_slot", 64'({mem_f[0][6], mem_k[0][6], mem_a[0][6]}), 64'({1'b1, 32'h77, 5'd7}));
        lit("post_rst_occ", 64'(occupancy), 64'd1);

        // Self-sustaining collision loop forces every insert to fail.
        clear_tables();
        preload(1'b0, 5'd3, 32'h11, 5'd9);
        preload(1'b1, 5'd9, 32'h33, 5'd3);
        for (int i = 0; i < 256; i++) begin
            insert(32'(32'h100 + i), 5'd3, 5'd9, 1'b0);
            wait_done();
            if (i == 254) lit("sat_255th", 64'(fail_count), 64'd255);
        end
        lit("sat_256th", 64'({fail_count, done_ok}), 64'({8'd255, 1'b0}));

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
